alu32_op_sequencer: RTL and testbench
=====================================

Name: alu32_op_sequencer

Overview:
Command-side initiator for the 32-bit clocked ALU. It accepts operation requests (a, b, sel, tag) over a valid/ready interface and drives the ALU operand and select inputs from registers. After a fixed ALU latency it samples the ALU output and returns result, sel and tag over a second valid/ready interface. It sits between a host or test sequencer and the ALU, and replaces open-loop stimulus with a handshaked, one-outstanding-op protocol.

Parameters:
WIDTH, 32, operand/result width
ALU_LAT, 1, edges from alu_a/alu_b/alu_sel change until alu_out is valid (0 = combinational ALU); range 0..15
TAG_W, 4, request tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request this cycle
req_a  in  WIDTH  operand a
req_b  in  WIDTH  operand b
req_sel  in  4  ALU operation select, passed through uninterpreted
req_tag  in  TAG_W  request identifier, echoed on the response
alu_a  out  WIDTH  registered operand a to the ALU
alu_b  out  WIDTH  registered operand b to the ALU
alu_sel  out  4  registered select to the ALU
alu_out  in  WIDTH  ALU result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_result  out  WIDTH  captured alu_out
rsp_sel  out  4  sel of the completed op
rsp_tag  out  TAG_W  tag of the completed op
busy  out  1  high in WAIT or RESP
op_count  out  16  completed-response count, wraps at 16'hFFFF to 0

Behaviour:
- Reset: clk and rst as named. rst is asynchronous and active-high; the same rule applies mid-operation, where it discards any in-flight op. While rst is high: state=IDLE, alu_a/alu_b/alu_sel=0, rsp_valid=0, rsp_result/rsp_sel/rsp_tag=0, op_count=0, wait counter=0, busy=0.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). It is combinational and does not depend on req_valid.
- Accept: an op is accepted at an edge where req_valid & req_ready.
  - req_a, req_b and req_sel load into alu_a, alu_b and alu_sel.
  - req_tag and req_sel load into internal hold registers.
  - The wait counter loads ALU_LAT.
  - Next state is WAIT.
- WAIT:
  - If the counter is nonzero, it decrements each edge.
  - At the edge where the counter is 0, alu_out is captured into rsp_result, hold tag/sel are copied to rsp_tag/rsp_sel, rsp_valid is set to 1, and next state is RESP.
  - Result: accept at edge E0 gives rsp_valid high after edge E(ALU_LAT+1).
- RESP:
  - rsp_* stay stable while rsp_valid & !rsp_ready.
  - On rsp_ready, op_count increments by 1, modulo 2^16.
  - If rsp_ready and no new accept, then rsp_valid=0 and next state is IDLE.
  - If rsp_ready and a new accept happens in the same edge, the new op loads and next state is WAIT. rsp_valid drops to 0 at that edge.
- Throughput: one op per ALU_LAT+2 cycles when the consumer keeps rsp_ready high.
- Hold behaviour:
  - alu_a, alu_b and alu_sel change only on accept; they hold their last values otherwise, including in IDLE.
  - rsp_result, rsp_sel and rsp_tag hold their last values after rsp_valid drops.
- Only one op is outstanding at a time. req_* is ignored outside an accept edge.
- busy = (state != IDLE).

Test Plan:
- Bench ALU stub: registered, ALU_LAT=1; sel 0000 = a+b, sel 0001 = a&b, sel 0010 = a|b, sel 0011 = a^b.
- Reset, then a=32'h1, b=32'h1, sel=0000, tag=3 with rsp_ready=1 -> req_ready high in IDLE; rsp_valid rises exactly 2 edges after accept with rsp_result=32'h2, rsp_tag=3; op_count=1.
- a={16{2'b01}}, b={16{2'b10}}, sel=0001, rsp_ready held 0 for 5 cycles -> rsp_result=32'h0 held stable; req_ready=0 throughout; releasing rsp_ready completes the response and op_count increments once.
- Back-to-back: 4 requests with req_valid and rsp_ready always 1 -> one response every 3 cycles, tags in order 0,1,2,3; each new accept occurs on the same edge as the previous response handshake.
- Assert rst mid-WAIT after accepting a=32'hFFFFFFFF, b=32'h1, sel=0011 -> immediately rsp_valid=0, alu_a/alu_b/alu_sel=0, op_count=0, busy=0; after rst release the next op completes normally.
- ALU_LAT=0 build with a combinational stub, a=32'h5555_5555, b=32'hAAAA_AAAA, sel=0010 -> rsp_valid one edge after accept with rsp_result=32'hFFFF_FFFF.
- Preload op_count to 16'hFFFF (65535 completions or a force) and complete one more op -> op_count=16'h0000.

Source files
------------

// File: rtl/alu32_op_sequencer.sv
// rtl/alu32_op_sequencer.sv - handshaked one-outstanding-op initiator for a clocked ALU
//
// Purpose: accepts (a, b, sel, tag) requests over valid/ready, drives the ALU
// operand/select registers, waits ALU_LAT edges, captures alu_out and returns
// (result, sel, tag) over a second valid/ready interface.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   req_valid/req_ready          request handshake
//   req_a, req_b, req_sel, req_tag  request payload
//   alu_a, alu_b, alu_sel        registered ALU inputs
//   alu_out                      ALU result
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_sel, rsp_tag response payload
//   busy                         high whenever an op is in flight or pending response
//   op_count                     completed-response count, wraps modulo 2^16
module alu32_op_sequencer #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_sel,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_sel,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             accept;
    logic             cnt_zero;

    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [TAG_W-1:0] hold_tag_q, hold_tag_d;
    logic [3:0]       hold_sel_q, hold_sel_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_sel_q, rsp_sel_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [15:0]      op_count_q, op_count_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_WAIT;
            S_WAIT: if (cnt_zero) state_d = S_RESP;
            S_RESP: begin
                // A new request can be taken on the same edge the response retires.
                if (accept) begin
                    state_d = S_WAIT;
                end else if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
        accept    = req_valid && req_ready;
        busy      = (state_q != S_IDLE);
        cnt_zero  = (wait_cnt_q == '0);
    end

    // Datapath next values
    always_comb begin
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        hold_tag_d   = hold_tag_q;
        hold_sel_d   = hold_sel_q;
        wait_cnt_d   = wait_cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_sel_d    = rsp_sel_q;
        rsp_tag_d    = rsp_tag_q;
        op_count_d   = op_count_q;

        if (accept) begin
            alu_a_d    = req_a;
            alu_b_d    = req_b;
            alu_sel_d  = req_sel;
            hold_tag_d = req_tag;
            hold_sel_d = req_sel;
            wait_cnt_d = CNT_W'(ALU_LAT);
        end else if ((state_q == S_WAIT) && !cnt_zero) begin
            wait_cnt_d = wait_cnt_q - 1'b1;
        end

        if ((state_q == S_WAIT) && cnt_zero) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_out;
            rsp_sel_d    = hold_sel_q;
            rsp_tag_d    = hold_tag_q;
        end

        // Payload is left in place after the handshake; only valid drops.
        if ((state_q == S_RESP) && rsp_ready) begin
            rsp_valid_d = 1'b0;
            op_count_d  = op_count_q + 16'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            hold_tag_q   <= '0;
            hold_sel_q   <= '0;
            wait_cnt_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_sel_q    <= '0;
            rsp_tag_q    <= '0;
            op_count_q   <= '0;
        end else begin
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            hold_tag_q   <= hold_tag_d;
            hold_sel_q   <= hold_sel_d;
            wait_cnt_q   <= wait_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_sel_q    <= rsp_sel_d;
            rsp_tag_q    <= rsp_tag_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_sel    = rsp_sel_q;
    assign rsp_tag    = rsp_tag_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu32_op_sequencer.sv
// tb/tb_alu32_op_sequencer.sv - self-checking bench for alu32_op_sequencer
module tb_alu32_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // DUT 1: registered ALU, ALU_LAT = 1
    logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [31:0] req_a, req_b, alu_a, alu_b, alu_out, rsp_result;
    logic [3:0]  req_sel, req_tag, alu_sel, rsp_sel, rsp_tag;
    logic [15:0] op_count;

    // DUT 2: combinational ALU, ALU_LAT = 0
    logic        req_valid2, req_ready2, rsp_valid2, rsp_ready2, busy2;
    logic [31:0] req_a2, req_b2, alu_a2, alu_b2, alu_out2, rsp_result2;
    logic [3:0]  req_sel2, req_tag2, alu_sel2, rsp_sel2, rsp_tag2;
    logic [15:0] op_count2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_count = 0;

    always #5 clk = ~clk;

    alu32_op_sequencer #(.WIDTH(32), .ALU_LAT(1), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_sel(rsp_sel), .rsp_tag(rsp_tag),
        .busy(busy), .op_count(op_count)
    );

    alu32_op_sequencer #(.WIDTH(32), .ALU_LAT(0), .TAG_W(4)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_a(req_a2), .req_b(req_b2), .req_sel(req_sel2), .req_tag(req_tag2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2), .alu_out(alu_out2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
        .rsp_result(rsp_result2), .rsp_sel(rsp_sel2), .rsp_tag(rsp_tag2),
        .busy(busy2), .op_count(op_count2)
    );

    // ALU stubs
    always_ff @(posedge clk) begin
        case (alu_sel)
            4'd0:    alu_out <= alu_a + alu_b;
            4'd1:    alu_out <= alu_a & alu_b;
            4'd2:    alu_out <= alu_a | alu_b;
            4'd3:    alu_out <= alu_a ^ alu_b;
            default: alu_out <= 32'h0;
        endcase
    end

    always_comb begin
        case (alu_sel2)
            4'd0:    alu_out2 = alu_a2 + alu_b2;
            4'd1:    alu_out2 = alu_a2 & alu_b2;
            4'd2:    alu_out2 = alu_a2 | alu_b2;
            4'd3:    alu_out2 = alu_a2 ^ alu_b2;
            default: alu_out2 = 32'h0;
        endcase
    end

    // Reference: result of an op from its operands, computed arithmetically.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [3:0] sel);
        logic [32:0] sum;
        logic [31:0] r;
        r = 32'h0;
        if (sel == 4'd0) begin
            sum = {1'b0, a} + {1'b0, b};
            r   = sum[31:0];
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (sel == 4'd1) r[i] = a[i] && b[i];
                if (sel == 4'd2) r[i] = a[i] || b[i];
                if (sel == 4'd3) r[i] = a[i] != b[i];
            end
        end
        return r;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One complete op on DUT 1, entered and left at a negedge with the DUT idle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                          input logic [3:0] tag, input int stall);
        int          lat;
        logic [31:0] held;
        req_a = a; req_b = b; req_sel = sel; req_tag = tag; req_valid = 1'b1;
        rsp_ready = (stall == 0);
        #1;
        check_eq("req_ready_idle", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom;
        check_eq("busy_wait", busy, 1'b1);
        check_eq("alu_a_loaded", alu_a, a);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, 2);
        check_eq("rsp_result", rsp_result, ref_result(a, b, sel));
        check_eq("rsp_tag", rsp_tag, tag);
        check_eq("rsp_sel", rsp_sel, sel);
        held = rsp_result;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq("stall_valid", rsp_valid, 1'b1);
            check_eq("stall_ready", req_ready, 1'b0);
            check_eq("stall_result", rsp_result, held);
            check_eq("stall_count", op_count, 16'(exp_count));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_count = (exp_count + 1) % 65536;
        check_eq("rsp_dropped", rsp_valid, 1'b0);
        check_eq("op_count", op_count, 16'(exp_count));
        check_eq("busy_idle", busy, 1'b0);
        check_eq("result_held", rsp_result, held);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bb_a [4];
        logic [31:0] bb_b [4];
        int          acc_n, rsp_n, cyc, last_rsp, lat;
        logic        fire_req, fire_rsp;

        req_valid = 0; req_a = 0; req_b = 0; req_sel = 0; req_tag = 0; rsp_ready = 0;
        req_valid2 = 0; req_a2 = 0; req_b2 = 0; req_sel2 = 0; req_tag2 = 0; rsp_ready2 = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_op_count", op_count, 16'h0);
        check_eq("rst_alu_a", alu_a, 32'h0);
        check_eq("rst_rsp_result", rsp_result, 32'h0);
        check_eq("rst_req_ready", req_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Basic add and stalled AND
        run_op(32'h1, 32'h1, 4'd0, 4'd3, 0);
        run_op({16{2'b01}}, {16{2'b10}}, 4'd1, 4'd7, 5);

        // Back-to-back, four requests
        for (int k = 0; k < 4; k++) begin
            bb_a[k] = $urandom;
            bb_b[k] = $urandom;
        end
        acc_n = 0; rsp_n = 0; cyc = 0; last_rsp = -1;
        rsp_ready = 1'b1;
        #1;
        while (rsp_n < 4 && cyc < 30) begin
            if (acc_n < 4) begin
                req_valid = 1'b1;
                req_a = bb_a[acc_n]; req_b = bb_b[acc_n];
                req_sel = 4'(acc_n); req_tag = 4'(acc_n);
            end else begin
                req_valid = 1'b0;
            end
            fire_req = req_valid && req_ready;
            fire_rsp = rsp_valid && rsp_ready;
            if (fire_rsp) begin
                check_eq("b2b_tag", rsp_tag, 4'(rsp_n));
                check_eq("b2b_result", rsp_result, ref_result(bb_a[rsp_n], bb_b[rsp_n], 4'(rsp_n)));
                if (last_rsp >= 0) check_eq("b2b_interval", cyc - last_rsp, 3);
                if (acc_n < 4) check_eq("b2b_same_edge", fire_req, 1'b1);
                last_rsp = cyc;
                rsp_n++;
                exp_count = (exp_count + 1) % 65536;
            end
            if (fire_req) acc_n++;
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        check_eq("b2b_count", rsp_n, 4);
        check_eq("b2b_op_count", op_count, 16'(exp_count));

        // Randomized ops with random backpressure
        for (int n = 0; n < 40; n++) begin
            run_op($urandom, $urandom, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3));
        end

        // Reset while an op is in WAIT
        req_a = 32'hFFFF_FFFF; req_b = 32'h1; req_sel = 4'd3; req_tag = 4'd5; req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        exp_count = 0;
        check_eq("mid_rst_valid", rsp_valid, 1'b0);
        check_eq("mid_rst_alu_a", alu_a, 32'h0);
        check_eq("mid_rst_alu_b", alu_b, 32'h0);
        check_eq("mid_rst_alu_sel", alu_sel, 4'h0);
        check_eq("mid_rst_count", op_count, 16'h0);
        check_eq("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(32'hFFFF_FFFF, 32'h1, 4'd3, 4'd9, 1);

        // Combinational ALU build
        req_a2 = 32'h5555_5555; req_b2 = 32'hAAAA_AAAA; req_sel2 = 4'd2; req_tag2 = 4'd6;
        req_valid2 = 1'b1; rsp_ready2 = 1'b1;
        #1;
        check_eq("lat0_req_ready", req_ready2, 1'b1);
        @(negedge clk);
        req_valid2 = 1'b0;
        lat = 0;
        while (!rsp_valid2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq("lat0_latency", lat, 1);
        check_eq("lat0_result", rsp_result2, 32'hFFFF_FFFF);
        check_eq("lat0_tag", rsp_tag2, 4'd6);
        @(negedge clk);
        check_eq("lat0_op_count", op_count2, 16'd1);
        check_eq("lat0_dropped", rsp_valid2, 1'b0);

        // op_count wrap
        force dut.op_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.op_count_q;
        @(negedge clk);
        check_eq("preload", op_count, 16'hFFFF);
        exp_count = 16'hFFFF;
        run_op(32'h10, 32'h20, 4'd0, 4'd1, 0);
        check_eq("wrap_zero", op_count, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
